game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
Top-level sequencer for the rhythm game. It walks the game through IDLE -> COUNTDOWN -> PLAY -> RESULT and gates the game timer. It accumulates score and combo from judgement results. It also arbitrates the single piezo between countdown/GO beeps and judgement hit sounds. It sits between button_ctrl/judgement_ctrl and piezo_ctrl/game_timer, all on the 50 MHz clock with the 1 ms tick from clk_div.

Parameters:
COUNT_MS, 1000, length of each countdown digit in ticks (ms)
COUNT_DIGITS, 3, countdown start digit (3,2,1)
BEEP_MS, 100, beep duration in ticks
BEEP_LIMIT, 25000, piezo half-period count for countdown beep (1 kHz)
GO_LIMIT, 12500, piezo half-period count for GO beep (2 kHz)
SCORE_W, 16, width of score/combo counters

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  asynchronous active-low reset (0 = reset)
i_tick  input  1  1 ms single-cycle pulse
i_start  input  1  debounced start, single-cycle pulse
i_restart  input  1  debounced restart, single-cycle pulse
i_game_end  input  1  level from note_gen; chart finished
i_judge_valid  input  1  single-cycle pulse; i_judge is valid
i_judge  input  2  00 MISS, 01 GOOD, 10 PERFECT, 11 reserved (ignored)
i_judge_play_en  input  1  judgement hit-sound request
i_judge_cnt_limit  input  32  judgement hit-sound half-period
o_state  output  2  0 IDLE, 1 COUNTDOWN, 2 PLAY, 3 RESULT
o_timer_en  output  1  game_timer run enable
o_timer_clr  output  1  single-cycle game_timer clear
o_count_digit  output  2  current countdown digit; 0 outside COUNTDOWN
o_score  output  SCORE_W  accumulated score
o_combo  output  SCORE_W  current combo
o_max_combo  output  SCORE_W  best combo this game
o_play_en  output  1  to piezo_ctrl
o_cnt_limit  output  32  to piezo_ctrl

Behaviour:
- All outputs are registered. An event on cycle N is visible on outputs at cycle N+1.
- Reset (rst=0, asynchronous) forces state IDLE and every output to 0, including o_cnt_limit.
- IDLE:
  - i_start -> COUNTDOWN. Clears score, combo and max_combo. Pulses o_timer_clr for 1 cycle. Loads digit=COUNT_DIGITS and ms counter=0. Starts a beep.
  - i_restart is ignored in IDLE. If i_start and i_restart arrive together, i_start wins.
- COUNTDOWN:
  - The ms counter increments on i_tick.
  - On the tick where counter==COUNT_MS-1: counter resets to 0.
    - digit>1: digit decrements and a new beep starts.
    - digit==1: state goes to PLAY, o_count_digit becomes 0, and the GO beep starts.
- PLAY:
  - o_timer_en=1.
  - On i_judge_valid:
    - PERFECT: score+=3, combo+=1.
    - GOOD: score+=1, combo+=1.
    - MISS: combo=0.
    - 11: no effect.
  - max_combo updates in the same cycle as combo (it compares the new combo value).
  - Score and combo saturate at 2^SCORE_W-1; they never wrap.
  - i_game_end=1 -> RESULT. A judgement that arrives in the same cycle is still counted.
- RESULT:
  - o_timer_en=0. Score, combo and max_combo hold.
  - i_start is ignored.
- Restart:
  - i_restart in COUNTDOWN, PLAY or RESULT behaves exactly like the IDLE start: it clears everything and goes to COUNTDOWN with o_timer_clr pulsed.
  - Restart beats i_game_end and i_judge_valid arriving in the same cycle; that judgement is discarded.
- Judgements outside PLAY are ignored.
- Beep timer:
  - On beep start, the beep counter loads BEEP_MS. It decrements on i_tick and the beep is active while the counter is nonzero.
  - A new beep start reloads the counter.
- Piezo arbitration, evaluated each cycle:
  - Beep active: o_play_en=1; o_cnt_limit=BEEP_LIMIT during countdown digits, GO_LIMIT for the GO beep.
  - Else, if state==PLAY: o_play_en=i_judge_play_en and o_cnt_limit=i_judge_cnt_limit (registered, 1-cycle latency).
  - Else: o_play_en=0 and o_cnt_limit=0.
  - The GO beep preempts hit sounds. Restart in RESULT aborts nothing, since no beep is active there.
- i_tick coinciding with any button or judgement event: both are processed in the same cycle.

Decomposition:
- Shared package game_pkg:
  - state encoding (ST_IDLE..ST_RESULT)
  - judge codes (JUDGE_MISS/GOOD/PERFECT)
  - score weights (PTS_PERFECT=3, PTS_GOOD=1)
  - default piezo limits
- One sub-module, tick_down_counter: loadable, decrements on i_tick, outputs a zero flag. Instantiate it twice: countdown ms counter and beep counter.

Test Plan:
All scenarios use COUNT_MS=4, BEEP_MS=2, and a tick every 10 clocks.
- Reset mid-PLAY (rst=0 for 1 cycle, asynchronous) -> o_state=0, o_timer_en=0, o_score=0 and o_play_en=0 immediately, without waiting for a clock edge.
- i_start in IDLE -> next cycle: o_state=1, o_count_digit=3, o_timer_clr=1 for exactly 1 cycle, o_play_en=1, o_cnt_limit=25000. After 2 ticks o_play_en=0. After 4 ticks digit=2. After 12 ticks: o_state=2, o_timer_en=1, o_cnt_limit=12500.
- In PLAY, judges PERFECT, PERFECT, GOOD, MISS, GOOD -> o_score=8, o_combo=1, o_max_combo=3.
- With SCORE_W=4, 6 PERFECTs -> o_score saturates at 15 (no wrap).
- i_judge_play_en=1, limit=30000 during the GO beep -> o_cnt_limit stays 12500 until the beep ends, then becomes 30000 one cycle later.
- In PLAY, i_game_end=1 and i_restart in the same cycle -> o_state=1, o_score=0, o_timer_clr pulsed. Separately, in RESULT, i_start -> no change; i_restart -> o_state=1.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared encodings and constants for the rhythm-game sequencer.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_PLAY      = 2'd2,
    ST_RESULT    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    JUDGE_MISS    = 2'b00,
    JUDGE_GOOD    = 2'b01,
    JUDGE_PERFECT = 2'b10
  } judge_e;

  localparam int PTS_PERFECT = 3;
  localparam int PTS_GOOD    = 1;

  localparam int unsigned DEF_BEEP_LIMIT = 25000;
  localparam int unsigned DEF_GO_LIMIT   = 12500;

endpackage

// File: rtl/tick_down_counter.sv
// tick_down_counter: loadable down-counter stepped by the 1 ms tick.
module tick_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         tick_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (tick_i && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Zero as it stands once this cycle's tick lands; a concurrent load is ignored.
  assign zero_o = (cnt_q == '0) || (tick_i && cnt_q == W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: game sequencer, score/combo keeper and piezo arbiter.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int          COUNT_MS     = 1000,
  parameter int          COUNT_DIGITS = 3,
  parameter int          BEEP_MS      = 100,
  parameter int unsigned BEEP_LIMIT   = DEF_BEEP_LIMIT,
  parameter int unsigned GO_LIMIT     = DEF_GO_LIMIT,
  parameter int          SCORE_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_tick,
  input  logic               i_start,
  input  logic               i_restart,
  input  logic               i_game_end,
  input  logic               i_judge_valid,
  input  logic [1:0]         i_judge,
  input  logic               i_judge_play_en,
  input  logic [31:0]        i_judge_cnt_limit,
  output logic [1:0]         o_state,
  output logic               o_timer_en,
  output logic               o_timer_clr,
  output logic [1:0]         o_count_digit,
  output logic [SCORE_W-1:0] o_score,
  output logic [SCORE_W-1:0] o_combo,
  output logic [SCORE_W-1:0] o_max_combo,
  output logic               o_play_en,
  output logic [31:0]        o_cnt_limit
);

  localparam int MS_W   = $clog2(COUNT_MS + 1);
  localparam int BEEP_W = $clog2(BEEP_MS + 1);
  localparam logic [SCORE_W-1:0] SAT = '1;

  state_e             state_q, state_d;
  logic [1:0]         digit_q, digit_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] combo_q, combo_d;
  logic [SCORE_W-1:0] maxc_q, maxc_d;
  logic               go_q, go_d;
  logic               ten_q, ten_d;
  logic               clr_q, clr_d;
  logic               play_q, play_d;
  logic [31:0]        lim_q, lim_d;

  logic               start_ev, beep_start, ms_load;
  logic               ms_zero, beep_zero, hit;
  logic [SCORE_W:0]   pts, sum;

  tick_down_counter #(.W(MS_W)) u_ms (
    .clk        (clk),
    .rst        (rst),
    .load_i     (ms_load),
    .load_val_i (MS_W'(COUNT_MS)),
    .tick_i     (i_tick),
    .zero_o     (ms_zero)
  );

  tick_down_counter #(.W(BEEP_W)) u_beep (
    .clk        (clk),
    .rst        (rst),
    .load_i     (beep_start),
    .load_val_i (BEEP_W'(BEEP_MS)),
    .tick_i     (i_tick),
    .zero_o     (beep_zero)
  );

  always_comb begin
    state_d    = state_q;
    digit_d    = digit_q;
    score_d    = score_q;
    combo_d    = combo_q;
    maxc_d     = maxc_q;
    go_d       = go_q;
    clr_d      = 1'b0;
    beep_start = 1'b0;
    ms_load    = 1'b0;
    hit        = 1'b0;
    pts        = '0;
    sum        = '0;
    start_ev   = (state_q == ST_IDLE) ? i_start : i_restart;

    if (start_ev) begin
      state_d    = ST_COUNTDOWN;
      digit_d    = 2'(COUNT_DIGITS);
      score_d    = '0;
      combo_d    = '0;
      maxc_d     = '0;
      go_d       = 1'b0;
      clr_d      = 1'b1;
      beep_start = 1'b1;
      ms_load    = 1'b1;
    end else begin
      case (state_q)
        ST_COUNTDOWN: begin
          if (i_tick && ms_zero) begin
            ms_load    = 1'b1;
            beep_start = 1'b1;
            if (digit_q > 2'd1) begin
              digit_d = digit_q - 2'd1;
            end else begin
              state_d = ST_PLAY;
              digit_d = 2'd0;
              go_d    = 1'b1;
            end
          end
        end
        ST_PLAY: begin
          if (i_judge_valid) begin
            unique case (1'b1)
              (i_judge == JUDGE_PERFECT): begin
                pts = (SCORE_W+1)'(PTS_PERFECT);
                hit = 1'b1;
              end
              (i_judge == JUDGE_GOOD): begin
                pts = (SCORE_W+1)'(PTS_GOOD);
                hit = 1'b1;
              end
              (i_judge == JUDGE_MISS): combo_d = '0;
              default: ;
            endcase
          end
          if (hit) begin
            sum     = {1'b0, score_q} + pts;
            score_d = sum[SCORE_W] ? SAT : sum[SCORE_W-1:0];
            combo_d = (combo_q == SAT) ? SAT : combo_q + SCORE_W'(1);
          end
          if (combo_d > maxc_q) maxc_d = combo_d;
          if (i_game_end) state_d = ST_RESULT;
        end
        default: ;
      endcase
    end
  end

  // Beeps own the piezo; hit sounds only reach it in PLAY with no beep running.
  always_comb begin
    ten_d  = (state_d == ST_PLAY);
    play_d = 1'b0;
    lim_d  = '0;
    if (beep_start || !beep_zero) begin
      play_d = 1'b1;
      lim_d  = go_d ? 32'(GO_LIMIT) : 32'(BEEP_LIMIT);
    end else if (state_d == ST_PLAY) begin
      play_d = i_judge_play_en;
      lim_d  = i_judge_cnt_limit;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      digit_q <= '0;
      score_q <= '0;
      combo_q <= '0;
      maxc_q  <= '0;
      go_q    <= 1'b0;
      ten_q   <= 1'b0;
      clr_q   <= 1'b0;
      play_q  <= 1'b0;
      lim_q   <= '0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      score_q <= score_d;
      combo_q <= combo_d;
      maxc_q  <= maxc_d;
      go_q    <= go_d;
      ten_q   <= ten_d;
      clr_q   <= clr_d;
      play_q  <= play_d;
      lim_q   <= lim_d;
    end
  end

  assign o_state       = state_q;
  assign o_count_digit = digit_q;
  assign o_score       = score_q;
  assign o_combo       = combo_q;
  assign o_max_combo   = maxc_q;
  assign o_timer_en    = ten_q;
  assign o_timer_clr   = clr_q;
  assign o_play_en     = play_q;
  assign o_cnt_limit   = lim_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: directed bench, 16-bit and 4-bit score instances.
module tb_game_flow_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic        restart = 1'b0;
  logic        gend = 1'b0;
  logic        jv = 1'b0;
  logic [1:0]  judge = 2'b00;
  logic        jpe = 1'b0;
  logic [31:0] jlim = '0;

  logic [1:0]  a_state, a_digit, b_state, b_digit;
  logic        a_ten, a_clr, a_play, b_ten, b_clr, b_play;
  logic [15:0] a_score, a_combo, a_max;
  logic [3:0]  b_score, b_combo, b_max;
  logic [31:0] a_lim, b_lim;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] P = 2'b10;
  localparam logic [1:0] G = 2'b01;
  localparam logic [1:0] M = 2'b00;
  localparam logic [1:0] R = 2'b11;

  game_flow_ctrl #(.COUNT_MS(4), .BEEP_MS(2)) dut_a (
    .clk(clk), .rst(rst), .i_tick(tick), .i_start(start),
    .i_restart(restart), .i_game_end(gend), .i_judge_valid(jv),
    .i_judge(judge), .i_judge_play_en(jpe), .i_judge_cnt_limit(jlim),
    .o_state(a_state), .o_timer_en(a_ten), .o_timer_clr(a_clr),
    .o_count_digit(a_digit), .o_score(a_score), .o_combo(a_combo),
    .o_max_combo(a_max), .o_play_en(a_play), .o_cnt_limit(a_lim)
  );

  game_flow_ctrl #(.COUNT_MS(4), .BEEP_MS(2), .SCORE_W(4)) dut_b (
    .clk(clk), .rst(rst), .i_tick(tick), .i_start(start),
    .i_restart(restart), .i_game_end(gend), .i_judge_valid(jv),
    .i_judge(judge), .i_judge_play_en(jpe), .i_judge_cnt_limit(jlim),
    .o_state(b_state), .o_timer_en(b_ten), .o_timer_clr(b_clr),
    .o_count_digit(b_digit), .o_score(b_score), .o_combo(b_combo),
    .o_max_combo(b_max), .o_play_en(b_play), .o_cnt_limit(b_lim)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (9) cyc();
      tick = 1'b1;
      cyc();
      tick = 1'b0;
    end
  endtask

  task automatic jdg(input logic [1:0] j);
    judge = j;
    jv = 1'b1;
    cyc();
    jv = 1'b0;
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (3) cyc();
    chk("rst_state", 32'(a_state), 0);
    chk("rst_digit", 32'(a_digit), 0);
    chk("rst_play", 32'(a_play), 0);
    chk("rst_lim", a_lim, 0);
    chk("rst_score", 32'(a_score), 0);
    chk("rst_ten", 32'(a_ten), 0);
    rst = 1'b1;
    cyc();

    start = 1'b1;
    restart = 1'b1;
    cyc();
    start = 1'b0;
    restart = 1'b0;
    jpe = 1'b1;
    jlim = 32'd30000;
    chk("st_state", 32'(a_state), 1);
    chk("st_digit", 32'(a_digit), 3);
    chk("st_clr", 32'(a_clr), 1);
    chk("st_play", 32'(a_play), 1);
    chk("st_lim", a_lim, 25000);
    chk("st_b_state", 32'(b_state), 1);
    chk("st_b_digit", 32'(b_digit), 3);
    chk("st_b_clr", 32'(b_clr), 1);
    chk("st_b_play", 32'(b_play), 1);
    chk("st_b_lim", b_lim, 25000);
    cyc();
    chk("clr_1cyc", 32'(a_clr), 0);

    ticks(2);
    chk("beep_off", 32'(a_play), 0);
    chk("beep_off_lim", a_lim, 0);
    chk("digit3_hold", 32'(a_digit), 3);
    ticks(2);
    chk("digit2", 32'(a_digit), 2);
    chk("beep2_play", 32'(a_play), 1);
    chk("beep2_lim", a_lim, 25000);
    ticks(8);
    chk("play_state", 32'(a_state), 2);
    chk("play_ten", 32'(a_ten), 1);
    chk("play_digit", 32'(a_digit), 0);
    chk("go_lim", a_lim, 12500);
    chk("go_play", 32'(a_play), 1);
    chk("b_ten", 32'(b_ten), 1);

    ticks(1);
    chk("go_hold1", a_lim, 12500);
    repeat (9) cyc();
    chk("go_hold2", a_lim, 12500);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("hit_lim", a_lim, 30000);
    chk("hit_play", 32'(a_play), 1);
    jlim = 32'd20000;
    jpe = 1'b0;
    cyc();
    chk("hit_lim2", a_lim, 20000);
    chk("hit_play2", 32'(a_play), 0);
    jpe = 1'b1;
    jlim = 32'd30000;

    jdg(P);
    jdg(P);
    jdg(G);
    jdg(M);
    jdg(G);
    chk("seq_score", 32'(a_score), 8);
    chk("seq_combo", 32'(a_combo), 1);
    chk("seq_max", 32'(a_max), 3);
    chk("seq_b_score", 32'(b_score), 8);
    jdg(R);
    chk("rsv_score", 32'(a_score), 8);
    chk("rsv_combo", 32'(a_combo), 1);
    repeat (6) jdg(P);
    chk("p6_score", 32'(a_score), 26);
    chk("p6_combo", 32'(a_combo), 7);
    chk("p6_max", 32'(a_max), 7);
    chk("sat_score", 32'(b_score), 15);
    chk("sat_combo", 32'(b_combo), 7);
    chk("sat_max", 32'(b_max), 7);

    gend = 1'b1;
    restart = 1'b1;
    judge = P;
    jv = 1'b1;
    cyc();
    gend = 1'b0;
    restart = 1'b0;
    jv = 1'b0;
    chk("rs_state", 32'(a_state), 1);
    chk("rs_score", 32'(a_score), 0);
    chk("rs_combo", 32'(a_combo), 0);
    chk("rs_max", 32'(a_max), 0);
    chk("rs_clr", 32'(a_clr), 1);
    chk("rs_b_score", 32'(b_score), 0);
    cyc();
    chk("rs_clr_off", 32'(a_clr), 0);

    ticks(12);
    chk("play2_state", 32'(a_state), 2);
    ticks(2);
    jdg(G);
    chk("g_score", 32'(a_score), 1);
    gend = 1'b1;
    judge = G;
    jv = 1'b1;
    cyc();
    jv = 1'b0;
    chk("end_state", 32'(a_state), 3);
    chk("end_score", 32'(a_score), 2);
    chk("end_combo", 32'(a_combo), 2);
    chk("end_ten", 32'(a_ten), 0);
    cyc();
    chk("end_play", 32'(a_play), 0);
    chk("end_lim", a_lim, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("res_start_state", 32'(a_state), 3);
    chk("res_start_clr", 32'(a_clr), 0);
    jdg(P);
    chk("res_judge", 32'(a_score), 2);
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    chk("res_rs_state", 32'(a_state), 1);
    chk("res_rs_score", 32'(a_score), 0);
    chk("res_rs_clr", 32'(a_clr), 1);
    chk("res_rs_digit", 32'(a_digit), 3);
    jdg(P);
    chk("cd_judge", 32'(a_score), 0);
    gend = 1'b0;

    ticks(12);
    chk("play3_state", 32'(a_state), 2);
    jdg(P);
    chk("play3_score", 32'(a_score), 3);
    rst = 1'b0;
    #2;
    chk("arst_state", 32'(a_state), 0);
    chk("arst_ten", 32'(a_ten), 0);
    chk("arst_score", 32'(a_score), 0);
    chk("arst_play", 32'(a_play), 0);
    chk("arst_b_score", 32'(b_score), 0);
    cyc();
    rst = 1'b1;
    cyc();
    chk("arst_hold", 32'(a_state), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
